mul_step_sequencer: RTL

Hardwired control-step sequencer for the single-bus datapath. It generates every per-step control strobe (PCout, MARin, MDRin, Rin/Rout selects, Yin, Zin, ALUControl, LOin/HIin and the rest) so the fetch and execute sequences are produced in RTL instead of being driven by the bench. It covers three-register ALU ops, and MUL/DIV with HI/LO writeback. It sits beside the bus module, reads the IR contents, and waits on memory and, optionally, the ALU.

---
 rtl/seq_pkg.sv | 63 ++++++
 rtl/seq_ir_decode.sv | 52 +++++
 rtl/mul_step_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : seq_pkg
// Brief   : States, opcodes, ALUControl one-hots and IR field positions for the
//           control-step sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_ILL  = 4'd8
`ifdef SEQ_ALU_WAIT_EN
        ,S_T4W = 4'd9
`endif
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILL    = 2'd0,
        CLS_ALU    = 2'd1,
        CLS_MULDIV = 2'd2
    } opclass_t;

    localparam logic [4:0] C_OP_ADD = 5'b00011;
    localparam logic [4:0] C_OP_SUB = 5'b00100;
    localparam logic [4:0] C_OP_AND = 5'b00101;
    localparam logic [4:0] C_OP_OR  = 5'b00110;
    localparam logic [4:0] C_OP_SHR = 5'b00111;
    localparam logic [4:0] C_OP_SHL = 5'b01000;
    localparam logic [4:0] C_OP_MUL = 5'b01001;
    localparam logic [4:0] C_OP_DIV = 5'b01010;

    localparam logic [11:0] C_ALU_ADD = 12'h001;
    localparam logic [11:0] C_ALU_SUB = 12'h002;
    localparam logic [11:0] C_ALU_MUL = 12'h004;
    localparam logic [11:0] C_ALU_DIV = 12'h008;
    localparam logic [11:0] C_ALU_AND = 12'h010;
    localparam logic [11:0] C_ALU_OR  = 12'h020;
    localparam logic [11:0] C_ALU_SHR = 12'h040;
    localparam logic [11:0] C_ALU_SHL = 12'h080;

    localparam int C_IR_OP_MSB = 31;
    localparam int C_IR_OP_LSB = 27;
    localparam int C_IR_RA_MSB = 26;
    localparam int C_IR_RA_LSB = 23;
    localparam int C_IR_RB_MSB = 22;
    localparam int C_IR_RB_LSB = 19;
    localparam int C_IR_RC_MSB = 18;
    localparam int C_IR_RC_LSB = 15;

    function automatic logic [15:0] onehot16(input logic [3:0] n);
        return 16'h0001 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ir_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : seq_ir_decode
// Brief   : Combinational IR decode to opcode class, register one-hots and ALU op.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module seq_ir_decode
    import seq_pkg::*;
(
    input  logic [31:0] i_ir,
    output opclass_t    o_class,
    output logic [15:0] o_ra_oh,
    output logic [15:0] o_rb_oh,
    output logic [15:0] o_rc_oh,
    output logic [11:0] o_alu_ctl,
    output logic        o_illegal
);

    logic [4:0] w_op;
    logic       w_unused_ir;

    assign w_op        = i_ir[C_IR_OP_MSB:C_IR_OP_LSB];
    assign o_ra_oh     = onehot16(i_ir[C_IR_RA_MSB:C_IR_RA_LSB]);
    assign o_rb_oh     = onehot16(i_ir[C_IR_RB_MSB:C_IR_RB_LSB]);
    assign o_rc_oh     = onehot16(i_ir[C_IR_RC_MSB:C_IR_RC_LSB]);
    assign o_illegal   = (o_class == CLS_ILL);
    assign w_unused_ir = ^i_ir[14:0];

    always_comb begin
        o_class   = CLS_ALU;
        o_alu_ctl = 12'h000;
        case (w_op)
            C_OP_ADD: o_alu_ctl = C_ALU_ADD;
            C_OP_SUB: o_alu_ctl = C_ALU_SUB;
            C_OP_AND: o_alu_ctl = C_ALU_AND;
            C_OP_OR:  o_alu_ctl = C_ALU_OR;
            C_OP_SHR: o_alu_ctl = C_ALU_SHR;
            C_OP_SHL: o_alu_ctl = C_ALU_SHL;
            C_OP_MUL: begin
                o_class   = CLS_MULDIV;
                o_alu_ctl = C_ALU_MUL;
            end
            C_OP_DIV: begin
                o_class   = CLS_MULDIV;
                o_alu_ctl = C_ALU_DIV;
            end
            default:  o_class = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_step_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mul_step_sequencer
// Brief   : Hardwired fetch/execute control-step sequencer (ALU, MUL/DIV).
//           Define SEQ_ALU_WAIT_EN to add the T4W wait on alu_done for MUL/DIV.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module mul_step_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        alu_done,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        MDRRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [11:0] ALUControl,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_next;
    logic        r_t1_seen;
    opclass_t    w_class;
    logic [15:0] w_ra_oh;
    logic [15:0] w_rb_oh;
    logic [15:0] w_rc_oh;
    logic [11:0] w_alu_ctl;
    logic        w_illegal_op;

`ifndef SEQ_ALU_WAIT_EN
    logic w_unused_alu_done;
    assign w_unused_alu_done = alu_done;
`endif

    seq_ir_decode u_dec (
        .i_ir      (IR),
        .o_class   (w_class),
        .o_ra_oh   (w_ra_oh),
        .o_rb_oh   (w_rb_oh),
        .o_rc_oh   (w_rc_oh),
        .o_alu_ctl (w_alu_ctl),
        .o_illegal (w_illegal_op)
    );

    // r_t1_seen marks a stalled T1 so PCin/Zlowout fire only on its first cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_t1_seen <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_t1_seen <= (r_state == S_T1);
        end
    end

    always_comb begin
        w_next     = r_state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        PCin       = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Rout       = 16'h0000;
        Rin        = 16'h0000;
        ALUControl = 12'h000;
        done       = 1'b0;
        illegal    = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (run) w_next = S_T0;
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                MDRRead = 1'b1;
                MDRin   = 1'b1;
                PCin    = !r_t1_seen;
                Zlowout = !r_t1_seen;
                if (mem_ready) w_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_illegal_op) begin
                    w_next = S_ILL;
                end else begin
                    Rout   = w_rb_oh;
                    Yin    = 1'b1;
                    w_next = S_T4;
                end
            end
            S_T4: begin
                Rout       = w_rc_oh;
                Zin        = 1'b1;
                ALUControl = w_alu_ctl;
`ifdef SEQ_ALU_WAIT_EN
                w_next     = (w_class == CLS_MULDIV) ? S_T4W : S_T5;
`else
                w_next     = S_T5;
`endif
            end
`ifdef SEQ_ALU_WAIT_EN
            S_T4W: begin
                ALUControl = w_alu_ctl;
                if (alu_done) w_next = S_T5;
            end
`endif
            S_T5: begin
                Zlowout = 1'b1;
                if (w_class == CLS_MULDIV) begin
                    LOin   = 1'b1;
                    w_next = S_T6;
                end else begin
                    Rin    = w_ra_oh;
                    done   = 1'b1;
                    w_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                w_next   = run ? S_T0 : S_IDLE;
            end
            S_ILL: begin
                illegal = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
